rc_servo_scheduler: RTL and testbench

- Sits between `fport_radio` (upstream) and `dynamixel_sync_write` (downstream).
- Latches RC channels 0-3 as they arrive and scales each to a Dynamixel goal position (0..4095).
- Issues sync-write frames at a fixed update rate: one Torque Enable frame after reset, then periodic Goal Position frames.
- Holds frame fields stable for the whole transmission; sequences the send/sending handshake with a start timeout.

---
 rtl/rc_servo_scheduler_pkg.sv | 18 +
 rtl/rc_servo_scheduler_channel_scaler.sv | 36 +++
 rtl/rc_servo_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_rc_servo_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_servo_scheduler_pkg.sv
// Shared constants and FSM encoding for the RC-to-Dynamixel servo scheduler.
package rc_servo_scheduler_pkg;

  localparam logic [15:0] ADDR_TORQUE_ENABLE = 16'd64;
  localparam logic [15:0] ADDR_GOAL_POSITION = 16'd116;
  localparam logic [15:0] LEN_TORQUE         = 16'd1;
  localparam logic [15:0] LEN_POSITION       = 16'd4;
  localparam logic [10:0] CHANNEL_CENTER     = 11'd992;
  localparam logic [11:0] POSITION_MAX       = 12'd4095;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_END   = 2'd3
  } state_t;

endpackage

// File: rtl/rc_servo_scheduler_channel_scaler.sv
// Maps one raw RC channel to a 0..4095 goal position: clamp, offset, x2.5, saturate.
module channel_scaler
  import rc_servo_scheduler_pkg::*;
#(
  parameter int CHANNEL_MIN = 172,
  parameter int CHANNEL_MAX = 1811
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [10:0] i_value,
  output logic [11:0] o_position
);

  localparam logic [10:0] L_MIN = 11'(CHANNEL_MIN);
  localparam logic [10:0] L_MAX = 11'(CHANNEL_MAX);

  logic [10:0] w_clamped;
  logic [10:0] w_offset;
  logic [12:0] w_scaled;

  always_comb begin
    w_clamped = i_value;
    if (i_value < L_MIN) w_clamped = L_MIN;
    else if (i_value > L_MAX) w_clamped = L_MAX;
    w_offset = w_clamped - L_MIN;
    // x*2.5 as (x<<1) + (x>>1); 13 bits covers the full 11-bit offset range
    w_scaled = {1'b0, w_offset, 1'b0} + {3'b000, w_offset[10:1]};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) o_position <= 12'd0;
    else if (w_scaled > 13'(POSITION_MAX)) o_position <= POSITION_MAX;
    else o_position <= w_scaled[11:0];
  end

endmodule

// File: rtl/rc_servo_scheduler.sv
// Periodic Dynamixel sync-write scheduler: torque enable after reset, then goal positions.
// Optional FAILSAFE_EN adds a silence timeout that disables torque and the o_failsafe_active port.
module rc_servo_scheduler
  import rc_servo_scheduler_pkg::*;
#(
  parameter int CLOCK_FREQUENCY      = 12000000,
  parameter int UPDATE_HZ            = 50,
  parameter int CHANNEL_MIN          = 172,
  parameter int CHANNEL_MAX          = 1811,
  parameter int START_TIMEOUT_CYCLES = 1024,
  parameter int FAILSAFE_MS          = 500
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_channel_changed,
  input  logic [3:0]  i_channel_index,
  input  logic [10:0] i_channel_value,
  input  logic        i_dynamixel_sending,
  output logic        o_send,
  output logic [15:0] o_address,
  output logic [15:0] o_data_len,
  output logic [31:0] o_value1,
  output logic [31:0] o_value2,
  output logic [31:0] o_value3,
  output logic [31:0] o_value4,
  output logic        o_frame_fault,
`ifdef FAILSAFE_EN
  output logic        o_failsafe_active,
`endif
  output logic [1:0]  o_state
);

  localparam logic [31:0] L_PERIOD_LAST  = 32'(CLOCK_FREQUENCY / UPDATE_HZ - 1);
  localparam logic [31:0] L_TIMEOUT_LAST = 32'(START_TIMEOUT_CYCLES - 1);

  // Handshake: o_send is a one-cycle pulse with the frame fields already valid;
  // the fields hold until the next LOAD. The writer raises i_dynamixel_sending
  // to accept and drops it when done.
  state_t      r_state, w_next;
  logic [10:0] r_shadow [4];
  logic [11:0] w_pos [4];
  logic [31:0] r_value [4];
  logic [31:0] r_period_cnt, r_wait_cnt;
  logic [15:0] r_address, r_data_len;
  logic        r_pending, r_torque_done, r_frame_is_on, r_send, r_fault;
  logic        w_tick, w_load, w_clear_pending, w_timeout, w_frame_done, w_failsafe;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) r_shadow[i] <= CHANNEL_CENTER;
    end else if (i_channel_changed && i_channel_index[3:2] == 2'b00) begin
      r_shadow[i_channel_index[1:0]] <= i_channel_value;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_scaler
    channel_scaler #(.CHANNEL_MIN(CHANNEL_MIN), .CHANNEL_MAX(CHANNEL_MAX)) u_scaler (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_value   (r_shadow[g]),
      .o_position(w_pos[g])
    );
  end

  assign w_tick = (r_period_cnt == L_PERIOD_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_period_cnt <= 32'd0;
      r_pending    <= 1'b0;
    end else begin
      r_period_cnt <= w_tick ? 32'd0 : r_period_cnt + 32'd1;
      // a tick coinciding with the clear wins, so no period is lost
      r_pending    <= w_tick | w_timeout | (r_pending & ~w_clear_pending);
    end
  end

`ifdef FAILSAFE_EN
  localparam logic [31:0] L_SILENCE_LAST = 32'(FAILSAFE_MS * (CLOCK_FREQUENCY / 1000) - 1);
  logic [31:0] r_silence_cnt;
  logic        r_failsafe, r_off_sent, r_frame_is_off;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_silence_cnt <= 32'd0;
      r_failsafe    <= 1'b0;
    end else if (i_channel_changed) begin
      r_silence_cnt <= 32'd0;
      r_failsafe    <= 1'b0;
    end else if (r_silence_cnt == L_SILENCE_LAST) begin
      r_failsafe    <= 1'b1;
    end else begin
      r_silence_cnt <= r_silence_cnt + 32'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_channel_changed) r_off_sent <= 1'b0;
    else if (w_frame_done && r_frame_is_off) r_off_sent <= 1'b1;
  end

  assign w_failsafe        = r_failsafe;
  assign o_failsafe_active = r_failsafe;
`else
  assign w_failsafe = 1'b0;
`endif

  always_comb begin
    w_next          = r_state;
    w_load          = 1'b0;
    w_clear_pending = 1'b0;
    w_timeout       = 1'b0;
    w_frame_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending) begin
          w_clear_pending = 1'b1;
`ifdef FAILSAFE_EN
          // once torque-off has gone out, periodic frames are suppressed
          if (!(r_failsafe && r_off_sent)) w_next = ST_LOAD;
`else
          w_next = ST_LOAD;
`endif
        end
      end
      ST_LOAD: begin
        w_load = 1'b1;
        w_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (i_dynamixel_sending) w_next = ST_WAIT_END;
        else if (r_wait_cnt == L_TIMEOUT_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_WAIT_END: begin
        if (!i_dynamixel_sending) begin
          w_frame_done = 1'b1;
          w_next       = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_LOAD;
    else r_state <= w_next;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_send        <= 1'b0;
      r_fault       <= 1'b0;
      r_wait_cnt    <= 32'd0;
      r_address     <= ADDR_TORQUE_ENABLE;
      r_data_len    <= LEN_TORQUE;
      r_torque_done <= 1'b0;
      r_frame_is_on <= 1'b0;
`ifdef FAILSAFE_EN
      r_frame_is_off <= 1'b0;
`endif
      for (int i = 0; i < 4; i++) r_value[i] <= 32'd0;
    end else begin
      r_send     <= w_load;
      r_fault    <= w_timeout;
      r_wait_cnt <= w_load ? 32'd0 : r_wait_cnt + 32'd1;
      if (w_load) begin
`ifdef FAILSAFE_EN
        r_frame_is_off <= w_failsafe;
`endif
        if (w_failsafe) begin
          r_address     <= ADDR_TORQUE_ENABLE;
          r_data_len    <= LEN_TORQUE;
          r_torque_done <= 1'b0;
          r_frame_is_on <= 1'b0;
          for (int i = 0; i < 4; i++) r_value[i] <= 32'd0;
        end else if (!r_torque_done) begin
          r_address     <= ADDR_TORQUE_ENABLE;
          r_data_len    <= LEN_TORQUE;
          r_frame_is_on <= 1'b1;
          for (int i = 0; i < 4; i++) r_value[i] <= 32'd1;
        end else begin
          r_address     <= ADDR_GOAL_POSITION;
          r_data_len    <= LEN_POSITION;
          r_frame_is_on <= 1'b0;
          for (int i = 0; i < 4; i++) r_value[i] <= {20'd0, w_pos[i]};
        end
      end
      if (w_frame_done && r_frame_is_on) r_torque_done <= 1'b1;
    end
  end

  assign o_send        = r_send;
  assign o_frame_fault = r_fault;
  assign o_address     = r_address;
  assign o_data_len    = r_data_len;
  assign o_value1      = r_value[0];
  assign o_value2      = r_value[1];
  assign o_value3      = r_value[2];
  assign o_value4      = r_value[3];
  assign o_state       = r_state;

endmodule

// File: tb/tb_rc_servo_scheduler.sv
// Directed bench for rc_servo_scheduler with a behavioural sync-writer busy model.
`timescale 1ns/1ps
module tb_rc_servo_scheduler;

  localparam int CLK_HZ  = 100000;
  localparam int UPD_HZ  = 50;
  localparam int PERIOD  = 2000;
  localparam int TIMEOUT = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        channel_changed = 1'b0;
  logic [3:0]  channel_index = 4'd0;
  logic [10:0] channel_value = 11'd0;
  logic        dynamixel_sending = 1'b0;
  logic        o_send, o_frame_fault;
  logic [15:0] o_address, o_data_len;
  logic [31:0] o_value1, o_value2, o_value3, o_value4;
  logic [1:0]  o_state;
`ifdef FAILSAFE_EN
  logic        o_failsafe_active;
`endif

  int total = 0;
  int bad = 0;
  int send_count = 0;
  int fault_count = 0;
  int busy_len = 100;
  bit model_en = 1'b1;
  logic [31:0] exp_q[$];

  rc_servo_scheduler #(
    .CLOCK_FREQUENCY(CLK_HZ), .UPDATE_HZ(UPD_HZ), .CHANNEL_MIN(172), .CHANNEL_MAX(1811),
    .START_TIMEOUT_CYCLES(TIMEOUT), .FAILSAFE_MS(1)
  ) dut (
    .i_clock(clock), .i_reset(reset), .i_channel_changed(channel_changed),
    .i_channel_index(channel_index), .i_channel_value(channel_value),
    .i_dynamixel_sending(dynamixel_sending), .o_send(o_send), .o_address(o_address),
    .o_data_len(o_data_len), .o_value1(o_value1), .o_value2(o_value2),
    .o_value3(o_value3), .o_value4(o_value4), .o_frame_fault(o_frame_fault),
`ifdef FAILSAFE_EN
    .o_failsafe_active(o_failsafe_active),
`endif
    .o_state(o_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (o_send) send_count++;
    if (o_frame_fault) fault_count++;
  end

  // sync writer model: busy rises 3 cycles after send, lasts busy_len cycles
  initial begin
    forever begin
      @(negedge clock);
      if (o_send && model_en) begin
        repeat (3) @(negedge clock);
        dynamixel_sending = 1'b1;
        repeat (busy_len) @(negedge clock);
        dynamixel_sending = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic strobe(input logic [3:0] idx, input logic [10:0] val);
    @(negedge clock);
    channel_changed = 1'b1;
    channel_index   = idx;
    channel_value   = val;
    @(negedge clock);
    channel_changed = 1'b0;
  endtask

  task automatic wait_send(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (o_send) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (o_state == 2'd0 && !dynamixel_sending) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (o_send !== 1'b0) begin bad++; $display("FAIL reset_send: got %0b want 0", o_send); end
    total++; if (o_frame_fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0b want 0", o_frame_fault); end
    total++; if (o_address !== 16'd64) begin bad++; $display("FAIL reset_address: got %0d want 64", o_address); end
    total++; if (o_data_len !== 16'd1) begin bad++; $display("FAIL reset_len: got %0d want 1", o_data_len); end
    total++;
    if ({o_value1, o_value2, o_value3, o_value4} !== 128'd0) begin
      bad++; $display("FAIL reset_values: got %0d %0d %0d %0d want 0 0 0 0", o_value1, o_value2, o_value3, o_value4);
    end
    total++; if (o_state !== 2'd1) begin bad++; $display("FAIL reset_state: got %0d want 1", o_state); end
  endtask

  task automatic test_torque_frame();
    bit seen;
    reset = 1'b0;
    wait_send(10, seen);
    total++; if (!seen) begin bad++; $display("FAIL torque_send: no send within 10 cycles"); end
    total++; if (o_address !== 16'd64) begin bad++; $display("FAIL torque_address: got %0d want 64", o_address); end
    total++; if (o_data_len !== 16'd1) begin bad++; $display("FAIL torque_len: got %0d want 1", o_data_len); end
    total++;
    if ({o_value1, o_value2, o_value3, o_value4} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL torque_values: got %0d %0d %0d %0d want 1 1 1 1", o_value1, o_value2, o_value3, o_value4);
    end
    wait_idle(300, seen);
    total++; if (!seen) begin bad++; $display("FAIL torque_idle: not idle within 300 cycles"); end
    total++; if (send_count !== 1) begin bad++; $display("FAIL torque_single_send: got %0d want 1", send_count); end
  endtask

  task automatic test_positions();
    bit seen;
    logic [31:0] got [4];
    logic [31:0] want;
    strobe(4'd0, 11'd172);
    strobe(4'd1, 11'd992);
    strobe(4'd2, 11'd1811);
    strobe(4'd6, 11'd172);
    strobe(4'd3, 11'd2000);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd2050);
    exp_q.push_back(32'd4095);
    exp_q.push_back(32'd4095);
    wait_send(2 * PERIOD, seen);
    total++; if (!seen) begin bad++; $display("FAIL pos_send: no send within %0d cycles", 2 * PERIOD); end
    total++; if (o_address !== 16'd116) begin bad++; $display("FAIL pos_address: got %0d want 116", o_address); end
    total++; if (o_data_len !== 16'd4) begin bad++; $display("FAIL pos_len: got %0d want 4", o_data_len); end
    got = '{o_value1, o_value2, o_value3, o_value4};
    for (int i = 0; i < 4; i++) begin
      want = exp_q.pop_front();
      total++;
      if (got[i] !== want) begin bad++; $display("FAIL pos_value%0d: got %0d want %0d", i + 1, got[i], want); end
    end
  endtask

  task automatic test_update_during_frame();
    bit seen;
    repeat (20) @(negedge clock);
    total++; if (dynamixel_sending !== 1'b1 || o_state !== 2'd3) begin
      bad++; $display("FAIL upd_in_wait_end: got state %0d want 3", o_state);
    end
    strobe(4'd1, 11'd500);
    repeat (10) @(negedge clock);
    total++; if (o_value2 !== 32'd2050) begin bad++; $display("FAIL upd_hold_value2: got %0d want 2050", o_value2); end
    wait_send(2 * PERIOD, seen);
    total++; if (!seen) begin bad++; $display("FAIL upd_send: no send within %0d cycles", 2 * PERIOD); end
    total++; if (o_value2 !== 32'd820) begin bad++; $display("FAIL upd_new_value2: got %0d want 820", o_value2); end
    total++; if (o_value1 !== 32'd0) begin bad++; $display("FAIL upd_value1: got %0d want 0", o_value1); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int c0;
    wait_idle(300, seen);
    busy_len = 2 * PERIOD + 500;
    wait_send(2 * PERIOD, seen);
    total++; if (!seen) begin bad++; $display("FAIL b2b_send: no send within %0d cycles", 2 * PERIOD); end
    repeat (5) @(negedge clock);
    busy_len = 100;
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clock);
      if (!dynamixel_sending) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL b2b_busy_end: busy did not end"); end
    c0 = send_count;
    repeat (50) @(negedge clock);
    total++; if (send_count - c0 !== 1) begin bad++; $display("FAIL b2b_one_frame: got %0d sends want 1", send_count - c0); end
    total++; if (o_address !== 16'd116) begin bad++; $display("FAIL b2b_address: got %0d want 116", o_address); end
    repeat (1000) @(negedge clock);
    total++; if (send_count - c0 !== 1) begin bad++; $display("FAIL b2b_no_dup: got %0d sends want 1", send_count - c0); end
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    wait_idle(300, seen);
    model_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (o_value1 !== 32'd0 || o_address !== 16'd64) begin
      bad++; $display("FAIL to_reset: got addr %0d value1 %0d want 64 0", o_address, o_value1);
    end
    reset = 1'b0;
    wait_send(10, seen);
    total++; if (!seen || o_address !== 16'd64) begin
      bad++; $display("FAIL to_first_torque: got seen %0b addr %0d want 1 64", seen, o_address);
    end
    n = 0;
    while (n < 2000) begin
      @(negedge clock);
      n++;
      if (o_frame_fault) break;
    end
    total++; if (n !== TIMEOUT) begin bad++; $display("FAIL to_latency: got %0d cycles want %0d", n, TIMEOUT); end
    model_en = 1'b1;
    wait_send(PERIOD + 10, seen);
    total++; if (!seen) begin bad++; $display("FAIL to_retry_send: no retry within %0d cycles", PERIOD + 10); end
    total++; if (o_address !== 16'd64 || o_value1 !== 32'd1) begin
      bad++; $display("FAIL to_retry_torque: got addr %0d value1 %0d want 64 1", o_address, o_value1);
    end
    wait_idle(300, seen);
    total++; if (fault_count !== 1) begin bad++; $display("FAIL to_fault_count: got %0d want 1", fault_count); end
  endtask

`ifdef FAILSAFE_EN
  task automatic test_failsafe();
    bit seen;
    int c0;
    reset = 1'b0;
    wait_send(10, seen);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (o_failsafe_active) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL fs_enter: failsafe_active stayed 0"); end
    wait_send(PERIOD + 10, seen);
    total++; if (!seen || o_address !== 16'd64 || o_value1 !== 32'd0) begin
      bad++; $display("FAIL fs_torque_off: got seen %0b addr %0d value1 %0d want 1 64 0", seen, o_address, o_value1);
    end
    c0 = send_count;
    repeat (PERIOD + 100) @(negedge clock);
    total++; if (send_count !== c0) begin bad++; $display("FAIL fs_suppress: got %0d sends want 0", send_count - c0); end
    strobe(4'd0, 11'd992);
    @(negedge clock);
    total++; if (o_failsafe_active !== 1'b0) begin bad++; $display("FAIL fs_exit: got 1 want 0"); end
    for (int f = 0; f < 2; f++) begin
      seen = 1'b0;
      for (int i = 0; i < 2 * PERIOD; i++) begin
        @(negedge clock);
        channel_changed = (i % 40 == 0);
        channel_index   = 4'd0;
        channel_value   = 11'd992;
        if (o_send) begin seen = 1'b1; break; end
      end
      channel_changed = 1'b0;
      total++;
      if (!seen || o_address !== (f == 0 ? 16'd64 : 16'd116) || o_value1 !== (f == 0 ? 32'd1 : 32'd2050)) begin
        bad++; $display("FAIL fs_resume%0d: got seen %0b addr %0d value1 %0d", f, seen, o_address, o_value1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FAILSAFE_EN
    test_failsafe();
`else
    test_torque_frame();
    test_positions();
    test_update_during_frame();
    test_back_to_back();
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
